// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Multi-channel red/yellow/green traffic light controller.
//               A shared prescaler produces one tick every TICK_DIV cycles
//               while running. Each channel cycles RED -> GREEN -> YELLOW ->
//               RED, and each phase lasts its programmed number of ticks.
//               While paused, a configuration port writes the per-channel
//               phase times or loads a start phase.
//               Optional macro TL_PED_REQ_EN lets a pedestrian request cut
//               a green phase short, so that green ends two ticks later.
// Ports       : clk          system clock
//               rst          asynchronous, active-low reset
//               running      1 = timers advance and lights are driven
//               cfg_wr       one-cycle configuration write strobe
//               cfg_sel      target channel index
//               cfg_field    01 red, 10 yellow, 11 green time; 00 load phase
//               cfg_data     time in ticks, or phase code in [1:0]
//               ped_req      per-channel pedestrian request
//               light_color  channel i at [2i+1:2i]: 00 dark, 01 R, 10 Y, 11 G
//               phase_done   one-cycle pulse when channel i changes phase
//               cfg_err      one-cycle pulse after a rejected write
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module traffic_light_ctrl #(
    parameter int NUM_LIGHTS = 4,
    parameter int TIME_W     = 5,
    parameter int TICK_DIV   = 50000000,
    parameter int DEF_TIME   = 10,
    parameter int SEL_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    running,
    input  logic                    cfg_wr,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [1:0]              cfg_field,
    input  logic [TIME_W-1:0]       cfg_data,
    input  logic [NUM_LIGHTS-1:0]   ped_req,
    output logic [2*NUM_LIGHTS-1:0] light_color,
    output logic [NUM_LIGHTS-1:0]   phase_done,
    output logic                    cfg_err
);

    // The phase encoding doubles as the light_color code and matches the
    // cfg_field code of the time register that governs the phase.
    typedef enum logic [1:0] {
        ST_RED = 2'b01,
        ST_YEL = 2'b10,
        ST_GRN = 2'b11
    } phase_t;

    localparam int                 c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]  c_def_time  = TIME_W'(DEF_TIME);
    localparam logic [SEL_W:0]     c_num_ch    = (SEL_W + 1)'(NUM_LIGHTS);

    // ------------------------------------------------------------------
    // Shared tick prescaler; held at zero while paused so the first tick
    // always arrives TICK_DIV cycles after running rises.
    // ------------------------------------------------------------------
    logic [c_presc_w-1:0] r_presc;
    logic                 w_tick;

    assign w_tick = running && (r_presc == c_presc_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (!running || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Configuration acceptance: only while paused and to an existing channel.
    // ------------------------------------------------------------------
    logic w_cfg_ok;
    logic r_cfg_err;

    assign w_cfg_ok = cfg_wr && !running && ({1'b0, cfg_sel} < c_num_ch);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !w_cfg_ok;
        end
    end

    assign cfg_err = r_cfg_err;

`ifndef TL_PED_REQ_EN
    logic w_unused_ped;
    assign w_unused_ped = ^ped_req;
`endif

    // ------------------------------------------------------------------
    // Per-channel time registers and phase FSM.
    // ------------------------------------------------------------------
    genvar i;
    generate
        for (i = 0; i < NUM_LIGHTS; i++) begin : g_chan
            localparam logic [SEL_W-1:0] c_idx = SEL_W'(i);

            logic               w_hit;
            logic [TIME_W-1:0]  r_red, r_yel, r_grn;
            phase_t             r_phase, w_phase_nxt;
            logic [TIME_W-1:0]  r_count, w_count_nxt;
            logic               r_done, w_done_nxt;
            logic [TIME_W-1:0]  w_len, w_len_eff;

            assign w_hit = w_cfg_ok && (cfg_sel == c_idx);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_red <= c_def_time;
                    r_yel <= c_def_time;
                    r_grn <= c_def_time;
                end else if (w_hit) begin
                    case (cfg_field)
                        2'b01:   r_red <= cfg_data;
                        2'b10:   r_yel <= cfg_data;
                        2'b11:   r_grn <= cfg_data;
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_phase <= ST_RED;
                    r_count <= '0;
                    r_done  <= 1'b0;
                end else begin
                    r_phase <= w_phase_nxt;
                    r_count <= w_count_nxt;
                    r_done  <= w_done_nxt;
                end
            end

            always_comb begin
                w_len       = r_red;
                w_phase_nxt = r_phase;
                w_count_nxt = r_count;
                w_done_nxt  = 1'b0;

                case (r_phase)
                    ST_YEL:  w_len = r_yel;
                    ST_GRN:  w_len = r_grn;
                    default: w_len = r_red;
                endcase
                // A programmed length of zero behaves as a one-tick phase.
                w_len_eff = (w_len == '0) ? TIME_W'(1) : w_len;

                if (w_hit && (cfg_field == 2'b00)) begin
                    // Phase code 00 is not a light state; it restarts at red.
                    w_phase_nxt = (cfg_data[1:0] == 2'b00) ? ST_RED : phase_t'(cfg_data[1:0]);
                    w_count_nxt = '0;
                end else if (w_tick) begin
                    if (r_count == w_len_eff - TIME_W'(1)) begin
                        w_count_nxt = '0;
                        w_done_nxt  = 1'b1;
                        case (r_phase)
                            ST_RED:  w_phase_nxt = ST_GRN;
                            ST_GRN:  w_phase_nxt = ST_YEL;
                            default: w_phase_nxt = ST_RED;
                        endcase
`ifdef TL_PED_REQ_EN
                    end else if ((r_phase == ST_GRN) && ped_req[i] &&
                                 ((w_len_eff - r_count) > TIME_W'(2))) begin
                        // Jump so that exactly two more ticks of green remain.
                        w_count_nxt = w_len_eff - TIME_W'(2);
`endif
                    end else begin
                        w_count_nxt = r_count + TIME_W'(1);
                    end
                end
            end

            // Lights are dark while paused and while reset is held.
            assign light_color[2*i +: 2] = (rst && running) ? r_phase : 2'b00;
            assign phase_done[i]         = r_done;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Self-checking bench for traffic_light_ctrl. A tick-level
//               reference model (times, phase, elapsed ticks per channel)
//               is advanced once per clock and compared with the outputs
//               one time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam int NL = 4;
    localparam int TW = 5;
    localparam int TD = 4;
    localparam int DT = 10;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            running = 1'b0;
    logic            cfg_wr = 1'b0;
    logic [SW-1:0]   cfg_sel = '0;
    logic [1:0]      cfg_field = '0;
    logic [TW-1:0]   cfg_data = '0;
    logic [NL-1:0]   ped_req = '0;
    logic [2*NL-1:0] light_color;
    logic [NL-1:0]   phase_done;
    logic            cfg_err;

    traffic_light_ctrl #(
        .NUM_LIGHTS(NL), .TIME_W(TW), .TICK_DIV(TD), .DEF_TIME(DT), .SEL_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .running(running), .cfg_wr(cfg_wr),
        .cfg_sel(cfg_sel), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .ped_req(ped_req), .light_color(light_color),
        .phase_done(phase_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: time table indexed [channel][field code], where the
    // field code of a time register equals the colour code of its phase.
    int          m_time [NL][4];
    int          m_phase[NL];
    int          m_cnt  [NL];
    int          m_pc;
    logic [NL-1:0] m_done;
    logic        m_err;

    function automatic void m_reset();
        for (int c = 0; c < NL; c++) begin
            for (int f = 0; f < 4; f++) m_time[c][f] = DT;
            m_phase[c] = 1;
            m_cnt[c]   = 0;
        end
        m_pc   = 0;
        m_done = '0;
        m_err  = 1'b0;
    endfunction

    function automatic int next_colour(int p);
        if (p == 1) return 3;
        if (p == 3) return 2;
        return 1;
    endfunction

    task automatic m_edge();
        bit tick;
        bit ok;
        int len;
        if (!rst) begin
            m_reset();
        end else begin
            tick  = running && (m_pc == TD - 1);
            m_pc  = (running && !tick) ? m_pc + 1 : 0;
            ok    = cfg_wr && !running && (int'(cfg_sel) < NL);
            m_err = cfg_wr && !ok;
            m_done = '0;
            if (ok) begin
                if (cfg_field == 2'b00) begin
                    m_phase[cfg_sel] = (cfg_data[1:0] == 2'b00) ? 1 : int'(cfg_data[1:0]);
                    m_cnt[cfg_sel]   = 0;
                end else begin
                    m_time[cfg_sel][cfg_field] = int'(cfg_data);
                end
            end
            if (tick) begin
                for (int c = 0; c < NL; c++) begin
                    len = m_time[c][m_phase[c]];
                    if (len == 0) len = 1;
                    if (m_cnt[c] + 1 == len) begin
                        m_phase[c] = next_colour(m_phase[c]);
                        m_cnt[c]   = 0;
                        m_done[c]  = 1'b1;
`ifdef TL_PED_REQ_EN
                    end else if (m_phase[c] == 3 && ped_req[c] && (len - m_cnt[c] > 2)) begin
                        m_cnt[c] = len - 2;
`endif
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check();
        logic [2*NL-1:0] exp_col;
        for (int c = 0; c < NL; c++)
            exp_col[2*c +: 2] = (rst && running) ? 2'(m_phase[c]) : 2'b00;
        tests++;
        assert (light_color === exp_col) else begin
            fails++;
            $error("FAIL light_color t=%0t got %h exp %h", $time, light_color, exp_col);
        end
        tests++;
        assert (phase_done === m_done) else begin
            fails++;
            $error("FAIL phase_done t=%0t got %h exp %h", $time, phase_done, m_done);
        end
        tests++;
        assert (cfg_err === m_err) else begin
            fails++;
            $error("FAIL cfg_err t=%0t got %b exp %b", $time, cfg_err, m_err);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check();
    endtask

    task automatic wr(input int sel, input int field, input int data);
        cfg_wr    = 1'b1;
        cfg_sel   = SW'(sel);
        cfg_field = 2'(field);
        cfg_data  = TW'(data);
        step();
        cfg_wr    = 1'b0;
    endtask

    initial begin
        int ch;
        int n;
        m_reset();
        #1;
        check();
        repeat (3) step();
        rst = 1'b1;
        step();

        // Default times: 40 clk of red, then all channels green together.
        running = 1'b1;
        repeat (45) step();

        // ch1 with red=2, green=3, yellow=1, started in red.
        running = 1'b0;
        step();
        wr(1, 1, 2);
        wr(1, 3, 3);
        wr(1, 2, 1);
        wr(1, 0, 1);
        running = 1'b1;
        repeat (72) step();

        // Zero green time, and a load straight into yellow.
        running = 1'b0;
        step();
        wr(2, 3, 0);
        wr(2, 0, 3);
        wr(3, 0, 2);
        running = 1'b1;
        repeat (40) step();

        // Rejected writes: while running, and to a non-existent channel.
        wr(0, 1, 7);
        step();
        running = 1'b0;
        wr(5, 1, 7);
        step();

        // Long pause and resume.
        running = 1'b1;
        repeat (30) step();
        running = 1'b0;
        repeat (100) step();
        running = 1'b1;
        repeat (40) step();

        // Asynchronous reset in mid-phase, away from any clock edge.
        #3;
        rst = 1'b0;
        #1;
        m_reset();
        check();
        repeat (2) step();
        rst = 1'b1;
        repeat (50) step();

        // Pedestrian request during a 10-tick green on ch0.
        running = 1'b0;
        step();
        wr(0, 3, 10);
        wr(0, 0, 3);
        running = 1'b1;
        repeat (5) step();
        ped_req = 4'b0001;
        repeat (4) step();
        ped_req = 4'b0000;
        repeat (50) step();

        // Randomized reconfiguration, pauses, rejected writes and requests.
        for (int it = 0; it < 30; it++) begin
            running = 1'b0;
            step();
            ch = $urandom_range(0, NL - 1);
            for (int f = 1; f < 4; f++) wr(ch, f, $urandom_range(0, 6));
            wr(ch, 0, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) wr($urandom_range(NL, 7), $urandom_range(0, 3), $urandom_range(0, 31));
            running = 1'b1;
            n = $urandom_range(10, 120);
            for (int k = 0; k < n; k++) begin
                ped_req = NL'($urandom);
                case ($urandom_range(0, 19))
                    0: wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31));
                    1: begin
                        running = 1'b0;
                        repeat ($urandom_range(1, 8)) step();
                        running = 1'b1;
                    end
                    default: step();
                endcase
            end
        end
        ped_req = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
